// File: rtl/bank_req_arbiter.sv
// Round-robin arbiter that shares one mem bank controller among N_REQ requesters.
// Define BANK_ARB_TIMEOUT_EN to build the wait-for-ack timeout (TIMEOUT_CYCLES).

`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 8
`endif
`ifndef COL_ADDR_WIDTH
`define COL_ADDR_WIDTH 4
`endif
`ifndef TX_DATA_WIDTH
`define TX_DATA_WIDTH 8
`endif

module bank_req_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ-1:0]                  req_we,
  input  logic [N_REQ-1:0]                  req_pad,
  input  logic [N_REQ*`BANK_ADDR_WIDTH-1:0] req_row,
  input  logic [N_REQ*`COL_ADDR_WIDTH-1:0]  req_col,
  input  logic [N_REQ*`TX_DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]                  rsp_valid,
  output logic                              rsp_err,
  output logic [`TX_DATA_WIDTH-1:0]         rsp_data,
  output logic                              mem_read_en,
  output logic                              mem_write_en,
  output logic                              mem_pad_en,
  output logic [`BANK_ADDR_WIDTH-1:0]       mem_row_addr,
  output logic [`COL_ADDR_WIDTH-1:0]        mem_col_addr,
  output logic [`TX_DATA_WIDTH-1:0]         mem_vec,
  input  logic                              mem_ack,
  input  logic [`TX_DATA_WIDTH-1:0]         mem_vec_in
);

  localparam int AW = `BANK_ADDR_WIDTH;
  localparam int CW = `COL_ADDR_WIDTH;
  localparam int DW = `TX_DATA_WIDTH;
  localparam int PW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  if (N_REQ < 2) begin : g_bad_n_req
    $error("bank_req_arbiter: N_REQ must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("bank_req_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  logic [1:0]       state_q,     state_d;
  logic [PW-1:0]    rr_ptr_q,    rr_ptr_d;
  logic [PW-1:0]    grant_q,     grant_d;
  logic             rd_en_q,     rd_en_d;
  logic             wr_en_q,     wr_en_d;
  logic             pad_en_q,    pad_en_d;
  logic [AW-1:0]    row_q,       row_d;
  logic [CW-1:0]    col_q,       col_d;
  logic [DW-1:0]    vec_q,       vec_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_data_q,  rsp_data_d;

  logic             pick_found;
  logic [PW-1:0]    pick_idx;
  logic             sel_we, sel_pad;
  logic [AW-1:0]    sel_row;
  logic [CW-1:0]    sel_col;
  logic [DW-1:0]    sel_data;
  logic [N_REQ-1:0] grant_oh;

  assign grant_oh = N_REQ'(1) << grant_q;

  // Scan from rr_ptr upward, wrapping, so the requester after the last grant wins ties.
  always_comb begin
    logic [PW:0] slot;
    // NOTE: every combinational output gets a default first so no path infers a latch.
    pick_found = 1'b0;
    pick_idx   = '0;
    slot       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      slot = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (slot >= (PW+1)'(N_REQ)) slot = slot - (PW+1)'(N_REQ);
      if (!pick_found && req_valid[slot[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = slot[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_we   = 1'b0;
    sel_pad  = 1'b0;
    sel_row  = '0;
    sel_col  = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == PW'(i)) begin
        sel_we   = req_we[i];
        sel_pad  = req_pad[i];
        sel_row  = req_row[i*AW +: AW];
        sel_col  = req_col[i*CW +: CW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

`ifdef BANK_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    rd_en_d     = rd_en_q;
    wr_en_d     = wr_en_q;
    pad_en_d    = pad_en_q;
    row_d       = row_q;
    col_d       = col_q;
    vec_d       = vec_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
`ifdef BANK_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    rsp_err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d  = pick_idx;
          rd_en_d  = !sel_we;
          wr_en_d  = sel_we;
          pad_en_d = sel_we & sel_pad;
          row_d    = sel_row;
          col_d    = sel_col;
          vec_d    = sel_data;
          state_d  = S_ISSUE;
`ifdef BANK_ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      S_ISSUE: begin
        // Enables drop on the ack edge itself so the bank never sees a second strobe.
        if (mem_ack) begin
          if (rd_en_q) rsp_data_d = mem_vec_in;
          rd_en_d     = 1'b0;
          wr_en_d     = 1'b0;
          rsp_valid_d = grant_oh;
          state_d     = S_RESP;
        end
`ifdef BANK_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rd_en_d     = 1'b0;
          wr_en_d     = 1'b0;
          rsp_valid_d = grant_oh;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        rr_ptr_d = (grant_q == PW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // NOTE: datapath registers are reset too, since every output must read 0 out of reset.
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      pad_en_q    <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      vec_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      pad_en_q    <= pad_en_d;
      row_q       <= row_d;
      col_q       <= col_d;
      vec_q       <= vec_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef BANK_ARB_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign mem_read_en  = rd_en_q;
  assign mem_write_en = wr_en_q;
  assign mem_pad_en   = pad_en_q;
  assign mem_row_addr = row_q;
  assign mem_col_addr = col_q;
  assign mem_vec      = vec_q;

endmodule

// File: tb/tb_bank_req_arbiter.sv
// Directed bench for bank_req_arbiter: a scripted bank acks after a chosen number of enable cycles.
// The timeout scenario runs only when BANK_ARB_TIMEOUT_EN is defined.

`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 8
`endif
`ifndef COL_ADDR_WIDTH
`define COL_ADDR_WIDTH 4
`endif
`ifndef TX_DATA_WIDTH
`define TX_DATA_WIDTH 8
`endif

module tb_bank_req_arbiter;

  localparam int N  = 4;
  localparam int AW = `BANK_ADDR_WIDTH;
  localparam int CW = `COL_ADDR_WIDTH;
  localparam int DW = `TX_DATA_WIDTH;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we = '0;
  logic [N-1:0]    req_pad = '0;
  logic [N*AW-1:0] req_row = '0;
  logic [N*CW-1:0] req_col = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    rsp_valid;
  logic            rsp_err;
  logic [DW-1:0]   rsp_data;
  logic            mem_read_en, mem_write_en, mem_pad_en;
  logic [AW-1:0]   mem_row_addr;
  logic [CW-1:0]   mem_col_addr;
  logic [DW-1:0]   mem_vec;
  logic            mem_ack = 1'b0;
  logic [DW-1:0]   mem_vec_in = '0;

  int checks = 0;
  int errors = 0;

  // Results of the last bank_serve call.
  logic          s_ok, s_hold_ok, s_rd, s_we, s_pad;
  int            s_en_cycles;
  logic [N-1:0]  s_rsp_v;
  logic [DW-1:0] s_rsp_d, s_wdata;
  logic          s_rsp_e;
  logic [AW-1:0] s_row;
  logic [CW-1:0] s_col;
  logic [DW-1:0] last_rdata;

  bank_req_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_we(req_we), .req_pad(req_pad),
    .req_row(req_row), .req_col(req_col), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_pad_en(mem_pad_en),
    .mem_row_addr(mem_row_addr), .mem_col_addr(mem_col_addr), .mem_vec(mem_vec),
    .mem_ack(mem_ack), .mem_vec_in(mem_vec_in)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic pad, input logic [AW-1:0] row,
                         input logic [CW-1:0] col, input logic [DW-1:0] data);
    req_we[i]            = we;
    req_pad[i]           = pad;
    req_row[i*AW +: AW]  = row;
    req_col[i*CW +: CW]  = col;
    req_data[i*DW +: DW] = data;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Waits for an enable, acks after lat enable cycles (lat=0: never), returns in the RESP cycle.
  task automatic bank_serve(input int lat, input logic [DW-1:0] rdata);
    s_ok = 1'b0;
    s_hold_ok = 1'b1;
    s_en_cycles = 0;
    for (int t = 0; t < 10 && !(mem_read_en || mem_write_en); t++) tick();
    if (!(mem_read_en || mem_write_en)) return;
    s_rd = mem_read_en;
    s_we = mem_write_en;
    s_pad = mem_pad_en;
    s_row = mem_row_addr;
    s_col = mem_col_addr;
    s_wdata = mem_vec;
    for (int t = 0; t < 200; t++) begin
      if (!(mem_read_en || mem_write_en)) break;
      s_en_cycles++;
      if (mem_read_en !== s_rd || mem_write_en !== s_we || mem_pad_en !== s_pad ||
          mem_row_addr !== s_row || mem_col_addr !== s_col || mem_vec !== s_wdata ||
          (mem_read_en && mem_write_en))
        s_hold_ok = 1'b0;
      if (s_en_cycles == lat) begin
        mem_ack = 1'b1;
        mem_vec_in = rdata;
      end
      tick();
      mem_ack = 1'b0;
      mem_vec_in = '0;
    end
    if (mem_read_en || mem_write_en) return;
    s_rsp_v = rsp_valid;
    s_rsp_d = rsp_data;
    s_rsp_e = rsp_err;
    s_ok = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, mem_read_en, mem_write_en, mem_pad_en,
         mem_row_addr, mem_col_addr, mem_vec} !== '0) begin
      errors++;
      $display("FAIL reset.outputs: got rsp_valid=%b rd=%b wr=%b row=%h expected all zero",
               rsp_valid, mem_read_en, mem_write_en, mem_row_addr);
    end
    req_valid = '0;
    reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({mem_read_en, mem_write_en, rsp_valid} !== '0) begin
      errors++;
      $display("FAIL reset.idle_no_req: got rd=%b wr=%b rsp_valid=%b expected 0 0 0000",
               mem_read_en, mem_write_en, rsp_valid);
    end
  endtask

  task automatic test_single_read();
    set_req(1, 1'b0, 1'b0, AW'(5), CW'(2), '0);
    req_valid = 4'b0010;
    bank_serve(2, 8'hA5);
    checks++;
    if (s_ok !== 1'b1) begin
      errors++;
      $display("FAIL single_read.handshake: got ok=%b expected 1", s_ok);
    end
    checks++;
    if (s_en_cycles != 2 || s_rd !== 1'b1 || s_we !== 1'b0) begin
      errors++;
      $display("FAIL single_read.enable: got %0d cycles rd=%b wr=%b expected 2 cycles rd=1 wr=0",
               s_en_cycles, s_rd, s_we);
    end
    checks++;
    if (s_row !== AW'(5) || s_col !== CW'(2) || s_hold_ok !== 1'b1) begin
      errors++;
      $display("FAIL single_read.addr: got row=%h col=%h hold=%b expected row=05 col=2 hold=1",
               s_row, s_col, s_hold_ok);
    end
    checks++;
    if (s_rsp_v !== 4'b0010 || s_rsp_d !== 8'hA5 || s_rsp_e !== 1'b0) begin
      errors++;
      $display("FAIL single_read.rsp: got v=%b data=%h err=%b expected v=0010 data=a5 err=0",
               s_rsp_v, s_rsp_d, s_rsp_e);
    end
    last_rdata = 8'hA5;
    req_valid = '0;
    tick();
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL single_read.pulse_width: got rsp_valid=%b expected 0000", rsp_valid);
    end
  endtask

  task automatic test_write_then_read();
    logic [DW-1:0] stored;
    set_req(0, 1'b1, 1'b1, AW'(7), CW'(1), 8'h3C);
    req_valid = 4'b0001;
    bank_serve(2, 8'hEE);
    stored = s_wdata;
    checks++;
    if (s_ok !== 1'b1 || s_en_cycles != 2 || s_we !== 1'b1 || s_rd !== 1'b0) begin
      errors++;
      $display("FAIL write.enable: got ok=%b %0d cycles wr=%b rd=%b expected ok=1 2 cycles wr=1 rd=0",
               s_ok, s_en_cycles, s_we, s_rd);
    end
    checks++;
    if (s_row !== AW'(7) || s_col !== CW'(1) || s_wdata !== 8'h3C || s_pad !== 1'b1) begin
      errors++;
      $display("FAIL write.fields: got row=%h col=%h vec=%h pad=%b expected 07 1 3c 1",
               s_row, s_col, s_wdata, s_pad);
    end
    checks++;
    if (s_rsp_v !== 4'b0001 || s_rsp_d !== last_rdata) begin
      errors++;
      $display("FAIL write.rsp: got v=%b data=%h expected v=0001 data=%h (unchanged)",
               s_rsp_v, s_rsp_d, last_rdata);
    end
    set_req(1, 1'b0, 1'b0, AW'(7), CW'(1), '0);
    req_valid = 4'b0010;
    bank_serve(1, stored);
    checks++;
    if (s_ok !== 1'b1 || s_en_cycles != 1 || s_rd !== 1'b1 || s_row !== AW'(7)) begin
      errors++;
      $display("FAIL read_back.enable: got ok=%b %0d cycles rd=%b row=%h expected 1 1 1 07",
               s_ok, s_en_cycles, s_rd, s_row);
    end
    checks++;
    if (s_rsp_v !== 4'b0010 || s_rsp_d !== 8'h3C) begin
      errors++;
      $display("FAIL read_back.rsp: got v=%b data=%h expected v=0010 data=3c", s_rsp_v, s_rsp_d);
    end
    last_rdata = 8'h3C;
    req_valid = '0;
    tick();
  endtask

  task automatic test_skip_idle();
    do_reset();
    set_req(0, 1'b0, 1'b0, AW'(8'h11), CW'(3), '0);
    set_req(3, 1'b0, 1'b0, AW'(8'h33), CW'(4), '0);
    req_valid = 4'b0001;
    bank_serve(1, 8'h01);
    checks++;
    if (s_rsp_v !== 4'b0001) begin
      errors++;
      $display("FAIL skip.setup: got rsp_valid=%b expected 0001", s_rsp_v);
    end
    req_valid = 4'b1001;
    bank_serve(1, 8'h03);
    checks++;
    if (s_rsp_v !== 4'b1000 || s_row !== AW'(8'h33) || s_rsp_d !== 8'h03) begin
      errors++;
      $display("FAIL skip.first: got v=%b row=%h data=%h expected 1000 33 03", s_rsp_v, s_row, s_rsp_d);
    end
    bank_serve(2, 8'h04);
    checks++;
    if (s_rsp_v !== 4'b0001 || s_row !== AW'(8'h11) || s_rsp_d !== 8'h04) begin
      errors++;
      $display("FAIL skip.wrap: got v=%b row=%h data=%h expected 0001 11 04", s_rsp_v, s_row, s_rsp_d);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_v;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, AW'(8'h40 + i), CW'(i), '0);
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_v = '0;
      exp_v[g % N] = 1'b1;
      bank_serve(1 + (g % 2), DW'(8'h50 + g));
      checks++;
      if (s_ok !== 1'b1 || s_rsp_v !== exp_v || s_row !== AW'(8'h40 + (g % N)) ||
          s_rsp_d !== DW'(8'h50 + g)) begin
        errors++;
        $display("FAIL round_robin.grant%0d: got ok=%b v=%b row=%h data=%h expected v=%b row=%h data=%h",
                 g, s_ok, s_rsp_v, s_row, s_rsp_d, exp_v, AW'(8'h40 + (g % N)), DW'(8'h50 + g));
      end
    end
    last_rdata = 8'h54;
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_issue();
    set_req(2, 1'b1, 1'b0, AW'(8'h22), CW'(5), 8'h77);
    req_valid = 4'b0100;
    for (int t = 0; t < 10 && !mem_write_en; t++) tick();
    checks++;
    if (mem_write_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid.write_en: got %b expected 1", mem_write_en);
    end
    reset_n = 1'b0;
    tick();
    checks++;
    if ({mem_read_en, mem_write_en, mem_pad_en, rsp_valid, mem_row_addr} !== '0) begin
      errors++;
      $display("FAIL reset_mid.outputs: got rd=%b wr=%b v=%b row=%h expected all zero",
               mem_read_en, mem_write_en, rsp_valid, mem_row_addr);
    end
    tick();
    set_req(0, 1'b0, 1'b0, AW'(8'h11), CW'(3), '0);
    req_valid = 4'b0101;
    reset_n = 1'b1;
    bank_serve(1, 8'h99);
    checks++;
    if (s_ok !== 1'b1 || s_rsp_v !== 4'b0001 || s_row !== AW'(8'h11)) begin
      errors++;
      $display("FAIL reset_mid.rr_ptr: got ok=%b v=%b row=%h expected 1 0001 11", s_ok, s_rsp_v, s_row);
    end
    last_rdata = 8'h99;
    req_valid = '0;
    tick();
  endtask

`ifdef BANK_ARB_TIMEOUT_EN
  task automatic test_timeout();
    set_req(1, 1'b0, 1'b0, AW'(8'h61), CW'(1), '0);
    set_req(2, 1'b0, 1'b0, AW'(8'h62), CW'(2), '0);
    req_valid = 4'b0110;
    bank_serve(0, '0);
    checks++;
    if (s_ok !== 1'b1 || s_en_cycles != 8) begin
      errors++;
      $display("FAIL timeout.cycles: got ok=%b %0d cycles expected ok=1 8 cycles", s_ok, s_en_cycles);
    end
    checks++;
    if (s_rsp_v !== 4'b0010 || s_rsp_e !== 1'b1 || s_rsp_d !== last_rdata) begin
      errors++;
      $display("FAIL timeout.rsp: got v=%b err=%b data=%h expected 0010 1 %h",
               s_rsp_v, s_rsp_e, s_rsp_d, last_rdata);
    end
    req_valid = 4'b0100;
    bank_serve(1, 8'h5A);
    checks++;
    if (s_rsp_v !== 4'b0100 || s_rsp_e !== 1'b0 || s_rsp_d !== 8'h5A) begin
      errors++;
      $display("FAIL timeout.next: got v=%b err=%b data=%h expected 0100 0 5a", s_rsp_v, s_rsp_e, s_rsp_d);
    end
    req_valid = '0;
    tick();
  endtask
`endif

  initial begin
    last_rdata = '0;
    test_reset();
    test_single_read();
    test_write_then_read();
    test_skip_idle();
    test_round_robin();
    test_reset_mid_issue();
`ifdef BANK_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_req_arbiter.md
Name: bank_req_arbiter

Overview:
- Shares one `mem` bank controller between N_REQ requesters (per-machine scan units) using round-robin arbitration.
- Drives the bank's read_en/write_en/pad_en/row/col/data inputs, holds them stable until ack_out, then returns read data and a completion pulse to the granted requester.
- Sits between the machine array and each bank instance.

Parameters:
- N_REQ, 4, number of requesters; must be >= 2.
- TIMEOUT_CYCLES, 64, wait-for-ack limit. Used only with BANK_ARB_TIMEOUT_EN.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request.
- req_we  in  N_REQ  1=write, 0=read.
- req_pad  in  N_REQ  pad_en for writes.
- req_row  in  N_REQ*`BANK_ADDR_WIDTH  packed row addresses; requester i occupies slice i.
- req_col  in  N_REQ*`COL_ADDR_WIDTH  packed column addresses.
- req_data  in  N_REQ*`TX_DATA_WIDTH  packed write vectors.
- rsp_valid  out  N_REQ  one-hot, single-cycle completion pulse.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- rsp_data  out  `TX_DATA_WIDTH  read data, qualified by rsp_valid.
- mem_read_en  out  1  to bank read_en.
- mem_write_en  out  1  to bank write_en.
- mem_pad_en  out  1  to bank pad_en.
- mem_row_addr  out  `BANK_ADDR_WIDTH  to bank row_addr_in.
- mem_col_addr  out  `COL_ADDR_WIDTH  to bank col_addr_in.
- mem_vec  out  `TX_DATA_WIDTH  to bank partial_vec_in.
- mem_ack  in  1  from bank ack_out (combinational in the bank).
- mem_vec_in  in  `TX_DATA_WIDTH  from bank partial_vec_out.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; rr_ptr=0; state=IDLE.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid, grant the first set bit at or after rr_ptr, wrapping modulo N_REQ.
  - Latch the granted requester's we/pad/row/col/data into the mem_* registers.
  - Assert mem_read_en or mem_write_en (never both); go to ISSUE.
  - If no req_valid, stay in IDLE.
- ISSUE:
  - mem_* fields are held constant.
  - On a cycle where mem_ack=1: capture mem_vec_in into rsp_data (reads only; writes leave rsp_data unchanged), drop both enables at the next edge, go to RESP.
  - Ack is sampled on the same edge it is seen. This guarantees the bank never sees an enable in the cycle after ack, which prevents a duplicate WRITEBACK.
- RESP:
  - rsp_valid[grant]=1 for exactly one cycle.
  - rr_ptr <= (grant+1) mod N_REQ; go to IDLE.
- Minimum spacing between grants is 3 cycles (IDLE→ISSUE→RESP→IDLE). Back-to-back requests from different requesters are granted on consecutive IDLE visits.
- Requesters must hold req_valid and fields stable until their rsp_valid.
  - req_valid dropping mid-transaction is ignored; the transaction completes and rsp_valid still pulses.
  - A requester holding req_valid after rsp_valid issues a new request.
- Fairness: with all requesters active, each is served once per N_REQ grants.
- Read latency is set by the bank: 1 ISSUE cycle on a saved-row hit, 2 on a miss (FETCH_SAVE). Write completes after 2–3 ISSUE cycles.
- Reset asserted mid-transaction:
  - Enables go to 0 at the next edge; no rsp_valid is issued.
  - The in-flight request is lost; requesters must re-request.
- Packed slice i covers bits [i*W +: W].

Optional Feature:
- Macro: BANK_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to ISSUE and increments in each ISSUE cycle.
  - If it reaches TIMEOUT_CYCLES without mem_ack: drop enables, go to RESP, pulse rsp_valid with rsp_err=1 and rsp_data unchanged; rr_ptr advances normally.
- Without the macro:
  - No counter is built; rsp_err is tied 0.
  - ISSUE waits indefinitely for ack.

Test Plan:
- Single read: req_valid=4'b0010, we=0, row=5, col=2, bank returns 0xA5 with ack 2 cycles after enable → mem_read_en high exactly 2 cycles, rsp_valid=4'b0010 one cycle later, rsp_data=0xA5, rsp_err=0.
- Round-robin: all four req_valid held high from reset → grant order 0,1,2,3,0; each rsp_valid bit pulses once per 4 grants.
- Write then read same row: req0 writes 0x3C to row 7 col 1, then req1 reads row 7 col 1 → mem_write_en drops the cycle after ack (no second WRITEBACK); req1 rsp_data=0x3C.
- Skip idle requesters: rr_ptr=1, req_valid=4'b1001 → requester 3 granted before 0; rr_ptr then wraps to 0.
- Reset mid-ISSUE: pull reset_n low while mem_write_en=1 → next edge all mem enables=0, rsp_valid=0, rr_ptr=0.
- Timeout (BANK_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): mem_ack held 0 → enables drop after 8 ISSUE cycles, rsp_valid pulses with rsp_err=1; the next pending requester is then granted normally.
